// File: rtl/if_stage_if.sv
// IF-stage bus: instruction ROM port plus the IF/ID pipeline register outputs.
// The fetch stage is the master; the ROM/ID side is the slave.
interface if_stage_if #(
    parameter int unsigned ROM_AW = 10
);
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic [31:0]       pc_out;
    logic [31:0]       pc4_out;
    logic [31:0]       ir_out;
    logic              valid_out;

    modport master (
        output rom_addr,
        output pc_out,
        output pc4_out,
        output ir_out,
        output valid_out,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        input  pc_out,
        input  pc4_out,
        input  ir_out,
        input  valid_out,
        output rom_data
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register, stall/redirect handling,
// syscall halt/resume and saturating statistics counters.
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned ROM_AW   = 10,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    input  logic             halt,
    input  logic             resume,
    if_stage_if.master       bus,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e state_q, state_d;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc_out_q, pc_out_d;
    logic [31:0]      pc4_out_q, pc4_out_d;
    logic [31:0]      ir_out_q, ir_out_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic        run;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: halt only seen in RUN, resume only seen in HALTED.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:    if (halt)   state_d = StHalted;
            StHalted: if (resume) state_d = StRun;
            default:  state_d = StRun;
        endcase
    end

    // FSM outputs.
    always_comb begin
        run    = (state_q == StRun);
        halted = (state_q == StHalted);
    end

    // PC and IF/ID next values; redirect beats stall, everything holds while halted.
    always_comb begin
        pc_d      = pc_q;
        pc_out_d  = pc_out_q;
        pc4_out_d = pc4_out_q;
        ir_out_d  = ir_out_q;
        valid_d   = valid_q;
        if (run) begin
            if (redirect) begin
                pc_d      = redirect_pc;
                pc_out_d  = 32'h0;
                pc4_out_d = 32'h0;
                ir_out_d  = 32'h0;
                valid_d   = 1'b0;
            end else if (!stall) begin
                pc_d      = pc_plus4;
                pc_out_d  = pc_q;
                pc4_out_d = pc_plus4;
                ir_out_d  = bus.rom_data;
                valid_d   = 1'b1;
            end
        end
    end

    // Saturating statistics; the edge that enters HALTED still counts.
    always_comb begin
        cycle_d = cycle_q;
        stall_d = stall_q;
        flush_d = flush_q;
        if (run) begin
            if (cycle_q != {CNT_W{1'b1}}) begin
                cycle_d = cycle_q + CNT_W'(1);
            end
            if (stall && !redirect && (stall_q != {CNT_W{1'b1}})) begin
                stall_d = stall_q + CNT_W'(1);
            end
            if (redirect && (flush_q != {CNT_W{1'b1}})) begin
                flush_d = flush_q + CNT_W'(1);
            end
        end
    end

    // Datapath and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= PC_RESET;
            pc_out_q  <= 32'h0;
            pc4_out_q <= 32'h0;
            ir_out_q  <= 32'h0;
            valid_q   <= 1'b0;
            cycle_q   <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            pc_q      <= pc_d;
            pc_out_q  <= pc_out_d;
            pc4_out_q <= pc4_out_d;
            ir_out_q  <= ir_out_d;
            valid_q   <= valid_d;
            cycle_q   <= cycle_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    // Byte PC to ROM word address; low two bits never address the ROM.
    assign bus.rom_addr  = pc_q[ROM_AW+1:2];
    assign bus.pc_out    = pc_out_q;
    assign bus.pc4_out   = pc4_out_q;
    assign bus.ir_out    = ir_out_q;
    assign bus.valid_out = valid_q;
    assign cycle_cnt     = cycle_q;
    assign stall_cnt     = stall_q;
    assign flush_cnt     = flush_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a 32-bit-counter instance for function and a
// 4-bit-counter instance, on the same stimulus, for saturation.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, halt, resume;
    logic [31:0] redirect_pc;
    logic        halted, halted_s;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
    logic [3:0]  cycle_s, stall_s, flush_s;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    if_stage_if #(.ROM_AW(10)) bus ();
    if_stage_if #(.ROM_AW(10)) bus_s ();

    // ROM[i] = 32'h1000_0000 + i
    assign bus.rom_data   = 32'h1000_0000 + {22'b0, bus.rom_addr};
    assign bus_s.rom_data = 32'h1000_0000 + {22'b0, bus_s.rom_addr};

    if_stage #(.PC_RESET(32'h0), .ROM_AW(10), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .resume(resume), .bus(bus), .halted(halted),
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    if_stage #(.PC_RESET(32'h0), .ROM_AW(10), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .halt(halt), .resume(resume), .bus(bus_s), .halted(halted_s),
        .cycle_cnt(cycle_s), .stall_cnt(stall_s), .flush_cnt(flush_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; redirect = 0; halt = 0; resume = 0; redirect_pc = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        if (bus.pc_out !== 32'h0) $display("FAIL rst_pc_out got %h want %h", bus.pc_out, 32'h0);
        else n_pass++;
        n_total++;
        if (bus.valid_out !== 1'b0) $display("FAIL rst_valid got %b want 0", bus.valid_out);
        else n_pass++;
        n_total++;
        if (bus.ir_out !== 32'h0) $display("FAIL rst_ir got %h want %h", bus.ir_out, 32'h0);
        else n_pass++;
        n_total++;
        if (bus.rom_addr !== 10'd0) $display("FAIL rst_rom_addr got %0d want 0", bus.rom_addr);
        else n_pass++;
        n_total++;
        if (halted !== 1'b0) $display("FAIL rst_halted got %b want 0", halted);
        else n_pass++;
        n_total++;
        if (cycle_cnt !== 32'd0) $display("FAIL rst_cycle got %0d want 0", cycle_cnt);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_fetch();
        logic [31:0] exp_pc;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_pc = 32'(i) * 32'd4;
            if (bus.ir_out !== 32'h1000_0000 + 32'(i))
                $display("FAIL fetch_ir[%0d] got %h want %h", i, bus.ir_out, 32'h1000_0000 + 32'(i));
            else n_pass++;
            n_total++;
            if (bus.pc_out !== exp_pc)
                $display("FAIL fetch_pc[%0d] got %h want %h", i, bus.pc_out, exp_pc);
            else n_pass++;
            n_total++;
            if (bus.pc4_out !== exp_pc + 32'd4)
                $display("FAIL fetch_pc4[%0d] got %h want %h", i, bus.pc4_out, exp_pc + 32'd4);
            else n_pass++;
            n_total++;
            if (bus.valid_out !== 1'b1) $display("FAIL fetch_valid[%0d] got %b want 1", i, bus.valid_out);
            else n_pass++;
            n_total++;
        end
        if (cycle_cnt !== 32'd3) $display("FAIL fetch_cycle got %0d want 3", cycle_cnt);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_stall();
        rst = 1; step(); rst = 0;
        step(); step();  // pc = 8
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            if (bus.rom_addr !== 10'd2) $display("FAIL stall_rom_addr[%0d] got %0d want 2", i, bus.rom_addr);
            else n_pass++;
            n_total++;
            if (bus.pc_out !== 32'h4 || bus.ir_out !== 32'h1000_0001)
                $display("FAIL stall_ifid[%0d] got pc %h ir %h want pc 4 ir 10000001", i, bus.pc_out, bus.ir_out);
            else n_pass++;
            n_total++;
        end
        if (stall_cnt !== 32'd2) $display("FAIL stall_cnt got %0d want 2", stall_cnt);
        else n_pass++;
        n_total++;
        stall = 0;
        step();
        if (bus.pc_out !== 32'h8 || bus.ir_out !== 32'h1000_0002)
            $display("FAIL stall_release got pc %h ir %h want pc 8 ir 10000002", bus.pc_out, bus.ir_out);
        else n_pass++;
        n_total++;
        if (cycle_cnt !== 32'd5) $display("FAIL stall_cycle got %0d want 5", cycle_cnt);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_redirect();
        redirect = 1; redirect_pc = 32'h40; stall = 1;
        step();
        redirect = 0; stall = 0;
        if (bus.valid_out !== 1'b0 || bus.ir_out !== 32'h0 || bus.pc_out !== 32'h0)
            $display("FAIL redir_bubble got v %b ir %h pc %h want 0 0 0", bus.valid_out, bus.ir_out, bus.pc_out);
        else n_pass++;
        n_total++;
        if (bus.rom_addr !== 10'd16) $display("FAIL redir_rom_addr got %0d want 16", bus.rom_addr);
        else n_pass++;
        n_total++;
        if (flush_cnt !== 32'd1 || stall_cnt !== 32'd2)
            $display("FAIL redir_cnts got flush %0d stall %0d want 1 2", flush_cnt, stall_cnt);
        else n_pass++;
        n_total++;
        step();
        if (bus.pc_out !== 32'h40 || bus.ir_out !== 32'h1000_0010 || bus.pc4_out !== 32'h44)
            $display("FAIL redir_fetch got pc %h ir %h pc4 %h want 40 10000010 44",
                     bus.pc_out, bus.ir_out, bus.pc4_out);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_halt();
        halt = 1;
        step();  // normal fetch of 0x44 on the halting edge
        halt = 0;
        if (halted !== 1'b1) $display("FAIL halt_enter got %b want 1", halted);
        else n_pass++;
        n_total++;
        for (int i = 0; i < 5; i++) begin
            stall = (i % 2 == 0); redirect = (i % 3 != 2); redirect_pc = 32'h100;
            step();
            if (bus.rom_addr !== 10'd18 || bus.pc_out !== 32'h44 || bus.ir_out !== 32'h1000_0011)
                $display("FAIL halt_hold[%0d] got addr %0d pc %h ir %h want 18 44 10000011",
                         i, bus.rom_addr, bus.pc_out, bus.ir_out);
            else n_pass++;
            n_total++;
            if (cycle_cnt !== 32'd8 || stall_cnt !== 32'd2 || flush_cnt !== 32'd1)
                $display("FAIL halt_cnts[%0d] got %0d %0d %0d want 8 2 1", i, cycle_cnt, stall_cnt, flush_cnt);
            else n_pass++;
            n_total++;
        end
        idle_inputs();
        resume = 1;
        step();
        resume = 0;
        if (halted !== 1'b0 || bus.pc_out !== 32'h44 || cycle_cnt !== 32'd8)
            $display("FAIL resume_edge got halted %b pc %h cyc %0d want 0 44 8", halted, bus.pc_out, cycle_cnt);
        else n_pass++;
        n_total++;
        step();
        if (bus.pc_out !== 32'h48 || bus.ir_out !== 32'h1000_0012 || bus.valid_out !== 1'b1)
            $display("FAIL resume_fetch got pc %h ir %h v %b want 48 10000012 1",
                     bus.pc_out, bus.ir_out, bus.valid_out);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_halt_redirect();
        halt = 1; redirect = 1; redirect_pc = 32'h20;
        step();
        idle_inputs();
        if (halted !== 1'b1 || bus.rom_addr !== 10'd8 || bus.valid_out !== 1'b0)
            $display("FAIL halt_redir got halted %b addr %0d v %b want 1 8 0", halted, bus.rom_addr, bus.valid_out);
        else n_pass++;
        n_total++;
        if (flush_cnt !== 32'd2) $display("FAIL halt_redir_flush got %0d want 2", flush_cnt);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_saturate();
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 14; i++) step();
        if (cycle_s !== 4'hE) $display("FAIL sat_pre got %h want e", cycle_s);
        else n_pass++;
        n_total++;
        for (int i = 0; i < 6; i++) step();
        if (cycle_s !== 4'hF) $display("FAIL sat_hold got %h want f", cycle_s);
        else n_pass++;
        n_total++;
        if (cycle_cnt !== 32'd20 || bus.rom_addr !== 10'd20)
            $display("FAIL sat_wide got cyc %0d addr %0d want 20 20", cycle_cnt, bus.rom_addr);
        else n_pass++;
        n_total++;
        halt = 1; stall = 1;
        step();
        halt = 0; stall = 0;
        if (halted !== 1'b1 || cycle_s !== 4'hF || stall_s !== 4'h1)
            $display("FAIL sat_halt got halted %b cyc %h stl %h want 1 f 1", halted, cycle_s, stall_s);
        else n_pass++;
        n_total++;
        rst = 1;
        step();
        rst = 0;
        if (halted !== 1'b0 || bus.rom_addr !== 10'd0 || bus.valid_out !== 1'b0)
            $display("FAIL halt_rst got halted %b addr %0d v %b want 0 0 0", halted, bus.rom_addr, bus.valid_out);
        else n_pass++;
        n_total++;
        if (cycle_s !== 4'h0 || stall_s !== 4'h0 || cycle_cnt !== 32'd0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
            $display("FAIL halt_rst_cnts got %h %h %0d %0d %0d want all 0",
                     cycle_s, stall_s, cycle_cnt, stall_cnt, flush_cnt);
        else n_pass++;
        n_total++;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_halt();
        test_halt_redirect();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
